// File: rtl/hazard_ctrl.sv
// Hazard, stall and flush controller for the 5-stage pipeline, with a memory wait watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MAX_WAIT = 15
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic [1:0] ex_result_src,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  input  logic       pc_src_e,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_WAIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          mem_hold;
  logic          load_use;
  logic          mem_a, wb_a, mem_b, wb_b;

  assign mem_a = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs1);
  assign wb_a  = wb_regwrite  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs1);
  assign mem_b = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs2);
  assign wb_b  = wb_regwrite  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs2);

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (reset) begin
      priority case (1'b1)
        mem_a:   forward_a_e = 2'b10;
        wb_a:    forward_a_e = 2'b01;
        default: forward_a_e = 2'b00;
      endcase
      priority case (1'b1)
        mem_b:   forward_b_e = 2'b10;
        wb_b:    forward_b_e = 2'b01;
        default: forward_b_e = 2'b00;
      endcase
    end
  end

  assign load_use = ex_regwrite && (ex_result_src == 2'b01)
                 && (ex_rd != 5'd0)
                 && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign mem_hold = (dmem_req && !dmem_ready)
                 || (state_q == S_ERROR);

  // Memory freeze dominates redirect, which dominates load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    priority case (1'b1)
      !reset: ;
      mem_hold: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end
      pc_src_e: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      load_use: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (dmem_req && !dmem_ready) begin
          state_d = S_WAIT;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT: begin
        if (!dmem_req || dmem_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == MAXC) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ERROR: err_d = 1'b1;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cyc_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f) stall_cyc_q <= stall_cyc_q + CNT_W'(1);
      if (flush_d) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a rule-level reference model.
// Perf counter checks are built only when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

  localparam int MAXW = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_regwrite, mem_regwrite, wb_regwrite;
  logic [1:0] ex_result_src;
  logic       pc_src_e, dmem_req, dmem_ready;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, mem_err;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] perf_stall_cyc, perf_flush_cnt;

  hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_result_src(ex_result_src),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_src_e(pc_src_e),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .mem_err(mem_err),
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt)
  );
`else
  hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_result_src(ex_result_src),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_src_e(pc_src_e),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .mem_err(mem_err)
  );
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: consecutive refused cycles, sticky error, event counts.
  int nr     = 0;
  bit err    = 1'b0;
  int pstall = 0;
  int pflush = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fsel(input logic [4:0] rs);
    if (!reset) return 2'b00;
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_model();
    nr = 0;
    err = 1'b0;
    pstall = 0;
    pflush = 0;
  endtask

  task automatic cycle();
    bit hold, lu;
    logic [3:0] es;
    logic [1:0] ef;
    @(negedge clk);
    if (!reset) clear_model();
    hold = (dmem_req && !dmem_ready) || err;
    lu = ex_regwrite && ex_result_src == 2'b01 && ex_rd != 0
      && (ex_rd == id_rs1 || ex_rd == id_rs2);
    es = 4'b0000;
    ef = 2'b00;
    if (!reset) begin
      es = 4'b0000;
    end else if (hold) begin
      es = 4'b1111;
    end else if (pc_src_e) begin
      ef = 2'b11;
    end else if (lu) begin
      es = 4'b1100;
      ef = 2'b01;
    end
    check("fwd_a", 32'(forward_a_e), 32'(fsel(ex_rs1)));
    check("fwd_b", 32'(forward_b_e), 32'(fsel(ex_rs2)));
    check("stall_fdem",
          32'({stall_f, stall_d, stall_e, stall_m}), 32'(es));
    check("flush_de", 32'({flush_d, flush_e}), 32'(ef));
    check("mem_err", 32'(mem_err), 32'(err));
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", 32'(perf_stall_cyc), 32'(pstall % 16));
    check("perf_flush", 32'(perf_flush_cnt), 32'(pflush % 16));
`endif
    @(posedge clk);
    if (!reset) begin
      clear_model();
    end else begin
      if (es[3]) pstall++;
      if (ef[1]) pflush++;
      if (!err) begin
        if (dmem_req && !dmem_ready) begin
          if (nr == MAXW) err = 1'b1;
          else nr++;
        end else begin
          nr = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0;
    ex_result_src = 0; pc_src_e = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic rand_inputs();
    id_rs1 = 5'($urandom_range(0, 3));
    id_rs2 = 5'($urandom_range(0, 3));
    ex_rs1 = 5'($urandom_range(0, 3));
    ex_rs2 = 5'($urandom_range(0, 3));
    ex_rd  = 5'($urandom_range(0, 3));
    mem_rd = 5'($urandom_range(0, 3));
    wb_rd  = 5'($urandom_range(0, 3));
    ex_regwrite   = 1'($urandom);
    mem_regwrite  = 1'($urandom);
    wb_regwrite   = 1'($urandom);
    ex_result_src = 2'($urandom);
    pc_src_e      = ($urandom_range(0, 3) == 0);
    dmem_req      = 1'($urandom);
    dmem_ready    = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #1;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();

    // Load-use on rs2 gives one bubble.
    ex_rd = 5; ex_regwrite = 1; ex_result_src = 2'b01; id_rs2 = 5;
    cycle();
    ex_regwrite = 0;
    cycle();

    // Forwarding priority and x0.
    ex_rs1 = 7; mem_rd = 7; wb_rd = 7;
    mem_regwrite = 1; wb_regwrite = 1;
    cycle();
    ex_rs1 = 0; mem_rd = 0;
    cycle();

    // Redirect beats load-use.
    ex_rd = 5; ex_regwrite = 1; ex_result_src = 2'b01; id_rs2 = 5;
    pc_src_e = 1;
    cycle();
    idle_inputs();

    // Three wait cycles then ready.
    dmem_req = 1; dmem_ready = 0;
    repeat (3) cycle();
    dmem_ready = 1;
    cycle();
    dmem_req = 0;
    cycle();

    // Watchdog timeout, then asynchronous reset.
    dmem_req = 1; dmem_ready = 0;
    repeat (18) cycle();
    dmem_ready = 1;
    cycle();
    reset = 1'b0;
    #1;
    check("async_mem_err", 32'(mem_err), 32'd0);
    check("async_stall", 32'(stall_f), 32'd0);
    clear_model();
    cycle();
    reset = 1'b1;
    dmem_req = 0;
    cycle();

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        dmem_req = 1; dmem_ready = 0;
        repeat (20) cycle();
      end
      rand_inputs();
      reset = ($urandom_range(0, 79) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
